// File: rtl/oper2_exec.sv
// PDP-8 Group 2 operate executor: evaluates the skip condition on the captured AC, then applies
// CLA, OSR and HLT with an optional user-mode trap. Driven by a start/done handshake.
module oper2_exec #(
    parameter int unsigned WIDTH       = 12,
    parameter bit          UM_TRAP_EN  = 1'b1,
    parameter bit          SKP_ONLY_G2 = 1'b1
) (
    input  logic             clk100,
    input  logic             reset_n,
    input  logic             start,
    input  logic [0:11]      instruction,
    input  logic [0:WIDTH-1] ac_in,
    input  logic             link_in,
    input  logic [0:WIDTH-1] switches,
    input  logic             user_mode,
    output logic             busy,
    output logic             done,
    output logic             skip,
    output logic [0:WIDTH-1] ac_out,
    output logic             ac_we,
    output logic             halt,
    output logic             user_trap
);

    typedef enum logic [1:0] {StIdle, StEval, StApply, StDone} state_e;

    state_e           state_q;
    logic [0:11]      ir_q;
    logic [0:WIDTH-1] ac_q;
    logic             link_q;
    logic             um_q;
    logic             skip_nx_q;

    logic             g2;
    logic             zero;
    logic             neg;
    logic             cond;
    logic             skip_eval;
    logic             priv;
    logic             osr_ok;
    logic [0:WIDTH-1] ac_apply;

    // With SKP_ONLY_G2=0 only the operate-class opcode is decoded; bits 3 and 11 are ignored.
    always_comb begin
        g2        = SKP_ONLY_G2 ? ((ir_q[0:3] == 4'b1111) && !ir_q[11])
                                : (ir_q[0:2] == 3'b111);
        zero      = (ac_q == '0);
        neg       = ac_q[0];
        cond      = (ir_q[5] & neg) | (ir_q[6] & zero) | (ir_q[7] & link_q);
        skip_eval = g2 & (ir_q[8] ? ~cond : cond);
        priv      = UM_TRAP_EN & um_q & (ir_q[9] | ir_q[10]);
        osr_ok    = g2 & ir_q[9] & ~priv;
        ac_apply  = ac_q;
        if (g2) begin
            ac_apply = (ir_q[4] ? '0 : ac_q) | (osr_ok ? switches : '0);
        end
    end

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            ac_q      <= '0;
            link_q    <= 1'b0;
            um_q      <= 1'b0;
            skip_nx_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            skip      <= 1'b0;
            ac_out    <= '0;
            ac_we     <= 1'b0;
            halt      <= 1'b0;
            user_trap <= 1'b0;
        end else begin
            done      <= 1'b0;
            ac_we     <= 1'b0;
            halt      <= 1'b0;
            user_trap <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        ir_q    <= instruction;
                        ac_q    <= ac_in;
                        link_q  <= link_in;
                        um_q    <= user_mode;
                        busy    <= 1'b1;
                        state_q <= StEval;
                    end
                end
                StEval: begin
                    skip_nx_q <= skip_eval;
                    state_q   <= StApply;
                end
                StApply: begin
                    skip      <= skip_nx_q;
                    ac_out    <= ac_apply;
                    done      <= 1'b1;
                    ac_we     <= g2 & (ir_q[4] | osr_ok);
                    halt      <= g2 & ir_q[10] & ~priv;
                    user_trap <= g2 & priv;
                    state_q   <= StDone;
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_oper2_exec.sv
// Self-checking bench for oper2_exec: 12-bit and 16-bit instances against an octal-mask model.
module tb_oper2_exec;

    typedef struct packed {
        logic        busy;
        logic        skip;
        logic [11:0] ac;
        logic        we;
        logic        halt;
        logic        trap;
    } res_t;

    typedef struct packed {
        logic        busy;
        logic        skip;
        logic [15:0] ac;
        logic        we;
        logic        halt;
        logic        trap;
    } res16_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        start12 = 1'b0, link12 = 1'b0, um12 = 1'b0;
    logic [11:0] ins12 = '0, ac12 = '0, sw12 = '0;
    logic        busy12, done12, skip12, we12, halt12, trap12;
    logic [11:0] acout12;

    logic        start16 = 1'b0, link16 = 1'b0, um16 = 1'b0;
    logic [11:0] ins16 = '0;
    logic [15:0] ac16 = '0, sw16 = '0;
    logic        busy16, done16, skip16, we16, halt16, trap16;
    logic [15:0] acout16;

    int n_checks = 0;
    int n_pass   = 0;

    oper2_exec #(.WIDTH(12)) u_dut12 (
        .clk100(clk), .reset_n(reset_n), .start(start12), .instruction(ins12), .ac_in(ac12),
        .link_in(link12), .switches(sw12), .user_mode(um12), .busy(busy12), .done(done12),
        .skip(skip12), .ac_out(acout12), .ac_we(we12), .halt(halt12), .user_trap(trap12)
    );

    oper2_exec #(.WIDTH(16)) u_dut16 (
        .clk100(clk), .reset_n(reset_n), .start(start16), .instruction(ins16), .ac_in(ac16),
        .link_in(link16), .switches(sw16), .user_mode(um16), .busy(busy16), .done(done16),
        .skip(skip16), .ac_out(acout16), .ac_we(we16), .halt(halt16), .user_trap(trap16)
    );

    // Behavioural reference: instruction fields addressed as octal masks, AC as an unsigned number.
    function automatic res_t model(input logic [11:0] ins, input logic [11:0] ac,
                                   input logic link, input logic [11:0] sw, input logic um);
        res_t r;
        logic c, priv, osr;
        r      = '0;
        r.busy = 1'b1;
        r.ac   = ac;
        if ((ins & 12'o7401) != 12'o7400) return r;
        c = ((ins & 12'o0100) != 0 && ac >= 12'o4000) || ((ins & 12'o0040) != 0 && ac == 0) ||
            ((ins & 12'o0020) != 0 && link);
        r.skip = ((ins & 12'o0010) != 0) ? !c : c;
        priv   = um && ((ins & 12'o0006) != 0);
        osr    = ((ins & 12'o0004) != 0) && !priv;
        if ((ins & 12'o0200) != 0) r.ac = '0;
        if (osr) r.ac = r.ac | sw;
        r.we   = ((ins & 12'o0200) != 0) || osr;
        r.halt = ((ins & 12'o0002) != 0) && !priv;
        r.trap = priv;
        return r;
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("busy=%0b skip=%0b ac=%o we=%0b halt=%0b trap=%0b",
                         r.busy, r.skip, r.ac, r.we, r.halt, r.trap);
    endfunction

    // Issue one instruction and scramble the captured inputs right after acceptance.
    task automatic issue12(input logic [11:0] ins, input logic [11:0] ac, input logic link,
                           input logic [11:0] sw, input logic um, output res_t obs,
                           output int lat);
        bit seen;
        @(negedge clk);
        ins12 = ins; ac12 = ac; link12 = link; sw12 = sw; um12 = um; start12 = 1'b1;
        @(posedge clk);
        #1;
        start12 = 1'b0;
        ins12 = 12'($urandom); ac12 = 12'($urandom);
        link12 = 1'($urandom); um12 = 1'($urandom);
        obs = '0; lat = 99; seen = 1'b0;
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge clk);
            if (done12) begin
                seen = 1'b1;
                lat  = i;
                obs  = '{busy: busy12, skip: skip12, ac: acout12, we: we12, halt: halt12,
                         trap: trap12};
            end
        end
    endtask

    task automatic issue16(input logic [11:0] ins, input logic [15:0] ac, output res16_t obs,
                           output int lat);
        bit seen;
        @(negedge clk);
        ins16 = ins; ac16 = ac; link16 = 1'b0; sw16 = '0; um16 = 1'b0; start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        ins16 = 12'($urandom); ac16 = 16'($urandom);
        obs = '0; lat = 99; seen = 1'b0;
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge clk);
            if (done16) begin
                seen = 1'b1;
                lat  = i;
                obs  = '{busy: busy16, skip: skip16, ac: acout16, we: we16, halt: halt16,
                         trap: trap16};
            end
        end
    endtask

    task automatic test_reset();
        res_t obs, exp;
        int   lat, pulses;
        #2;
        obs = '{busy: busy12, skip: skip12, ac: acout12, we: we12, halt: halt12, trap: trap12};
        n_checks++;
        if (obs !== res_t'('0) || done12 !== 1'b0)
            $display("FAIL reset_state: got %s done=%0b, want all zero", fmt(obs), done12);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        // Abandon an instruction in EVAL.
        @(negedge clk);
        ins12 = 12'o7500; ac12 = 12'o4000; start12 = 1'b1;
        @(posedge clk);
        #1;
        start12 = 1'b0;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (busy12 !== 1'b0) $display("FAIL reset_mid_busy: got %0b, want 0", busy12);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (done12) pulses++;
        end
        n_checks++;
        if (pulses != 0) $display("FAIL reset_mid_done: got %0d pulses, want 0", pulses);
        else n_pass++;
        issue12(12'o7500, 12'o4000, 1'b0, 12'o0, 1'b0, obs, lat);
        exp = model(12'o7500, 12'o4000, 1'b0, 12'o0, 1'b0);
        n_checks++;
        if (obs !== exp || lat != 3)
            $display("FAIL after_reset_sma: got %s lat=%0d, want %s lat=3", fmt(obs), lat,
                     fmt(exp));
        else n_pass++;
    endtask

    task automatic test_reverse_sense();
        res_t obs, exp;
        int   lat;
        logic [11:0] ac;
        logic link;
        issue12(12'o7450, 12'o0000, 1'b0, 12'o0, 1'b0, obs, lat);
        n_checks++;
        if (obs.skip !== 1'b0 || lat != 3)
            $display("FAIL sna_zero: got skip=%0b lat=%0d, want skip=0 lat=3", obs.skip, lat);
        else n_pass++;
        issue12(12'o7450, 12'o0001, 1'b0, 12'o0, 1'b0, obs, lat);
        n_checks++;
        if (obs.skip !== 1'b1) $display("FAIL sna_nonzero: got skip=%0b, want 1", obs.skip);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            ac   = (i == 0) ? 12'o0 : 12'($urandom);
            link = 1'(i);
            issue12(12'o7410, ac, link, 12'o0, 1'b0, obs, lat);
            exp = model(12'o7410, ac, link, 12'o0, 1'b0);
            n_checks++;
            if (obs !== exp || obs.skip !== 1'b1)
                $display("FAIL skp_%0d: got %s, want %s", i, fmt(obs), fmt(exp));
            else n_pass++;
        end
    endtask

    task automatic test_order();
        res_t obs;
        int   lat;
        issue12(12'o7640, 12'o0000, 1'b0, 12'o0, 1'b0, obs, lat);
        n_checks++;
        if (obs.skip !== 1'b1 || obs.ac !== 12'o0 || obs.we !== 1'b1)
            $display("FAIL sza_cla_zero: got %s, want skip=1 ac=0 we=1", fmt(obs));
        else n_pass++;
        issue12(12'o7640, 12'o0005, 1'b0, 12'o0, 1'b0, obs, lat);
        n_checks++;
        if (obs.skip !== 1'b0 || obs.ac !== 12'o0 || obs.we !== 1'b1)
            $display("FAIL sza_cla_five: got %s, want skip=0 ac=0 we=1", fmt(obs));
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done12 !== 1'b0 || we12 !== 1'b0 || acout12 !== 12'o0 || skip12 !== 1'b0)
            $display("FAIL pulse_width: got done=%0b we=%0b ac=%o skip=%0b, want 0 0 0 0",
                     done12, we12, acout12, skip12);
        else n_pass++;
    endtask

    task automatic test_las();
        res_t obs;
        int   lat;
        issue12(12'o7604, 12'o1234, 1'b0, 12'o0707, 1'b0, obs, lat);
        n_checks++;
        if (obs.ac !== 12'o0707 || obs.we !== 1'b1)
            $display("FAIL las: got ac=%o we=%0b, want ac=0707 we=1", obs.ac, obs.we);
        else n_pass++;
        issue12(12'o7404, 12'o1234, 1'b0, 12'o0707, 1'b0, obs, lat);
        n_checks++;
        if (obs.ac !== 12'o1737 || obs.we !== 1'b1)
            $display("FAIL osr: got ac=%o we=%0b, want ac=1737 we=1", obs.ac, obs.we);
        else n_pass++;
    endtask

    task automatic test_user_trap();
        res_t obs;
        int   lat;
        issue12(12'o7402, 12'o0123, 1'b0, 12'o0, 1'b1, obs, lat);
        n_checks++;
        if (obs.trap !== 1'b1 || obs.halt !== 1'b0 || obs.we !== 1'b0)
            $display("FAIL hlt_user: got %s, want trap=1 halt=0 we=0", fmt(obs));
        else n_pass++;
        issue12(12'o7402, 12'o0123, 1'b0, 12'o0, 1'b0, obs, lat);
        n_checks++;
        if (obs.trap !== 1'b0 || obs.halt !== 1'b1)
            $display("FAIL hlt_kernel: got %s, want trap=0 halt=1", fmt(obs));
        else n_pass++;
        issue12(12'o7644, 12'o0000, 1'b0, 12'o7777, 1'b1, obs, lat);
        n_checks++;
        if (obs.trap !== 1'b1 || obs.skip !== 1'b1 || obs.ac !== 12'o0 || obs.we !== 1'b1)
            $display("FAIL osr_user_cla: got %s, want trap=1 skip=1 ac=0 we=1", fmt(obs));
        else n_pass++;
    endtask

    task automatic test_random();
        res_t obs, exp;
        int   lat;
        logic [11:0] ins, ac, sw;
        logic link, um;
        for (int i = 0; i < 48; i++) begin
            ins  = ($urandom_range(0, 3) == 0) ? 12'($urandom)
                                               : (12'o7400 | 12'($urandom_range(0, 255)));
            case ($urandom_range(0, 3))
                0:       ac = 12'o0;
                1:       ac = 12'o4000;
                default: ac = 12'($urandom);
            endcase
            sw   = 12'($urandom);
            link = 1'($urandom);
            um   = 1'($urandom);
            issue12(ins, ac, link, sw, um, obs, lat);
            exp = model(ins, ac, link, sw, um);
            n_checks++;
            if (obs !== exp || lat != 3)
                $display("FAIL rand_%0d ins=%o ac=%o: got %s lat=%0d, want %s lat=3", i, ins,
                         ac, fmt(obs), lat, fmt(exp));
            else n_pass++;
        end
    endtask

    task automatic test_width16();
        res16_t obs;
        int     lat;
        issue16(12'o7500, 16'h8000, obs, lat);
        n_checks++;
        if (obs.skip !== 1'b1 || obs.we !== 1'b0 || lat != 3)
            $display("FAIL w16_sma: got skip=%0b we=%0b lat=%0d, want 1 0 3", obs.skip,
                     obs.we, lat);
        else n_pass++;
        issue16(12'o7200, 16'h8000, obs, lat);
        n_checks++;
        if (obs.skip !== 1'b0 || obs.ac !== 16'h8000 || obs.we !== 1'b0 || lat != 3)
            $display("FAIL w16_group1: got skip=%0b ac=%h we=%0b lat=%0d, want 0 8000 0 3",
                     obs.skip, obs.ac, obs.we, lat);
        else n_pass++;
    endtask

    // start held high: done must recur every 4 cycles.
    task automatic test_back_to_back(input bit wide);
        int q[$];
        int expd[5] = '{3, 7, 11, 15, 19};
        @(negedge clk);
        if (wide) begin
            ins16 = 12'o7200; ac16 = 16'h8000; start16 = 1'b1;
        end else begin
            ins12 = 12'o7410; ac12 = 12'o0017; start12 = 1'b1;
        end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (wide ? done16 : done12) q.push_back(i);
        end
        start12 = 1'b0;
        start16 = 1'b0;
        n_checks++;
        if (q.size() != 5) $display("FAIL b2b_count_w%0d: got %0d, want 5", wide, q.size());
        else n_pass++;
        for (int i = 0; i < 5 && i < q.size(); i++) begin
            n_checks++;
            if (q[i] != expd[i])
                $display("FAIL b2b_cycle_w%0d_%0d: got %0d, want %0d", wide, i, q[i], expd[i]);
            else n_pass++;
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_reverse_sense();
        test_order();
        test_las();
        test_user_trap();
        test_random();
        test_width16();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
